add2_unpack: RTL and testbench



---
 rtl/add2_unpack_if.sv | 24 ++
 rtl/add2_unpack.sv | 114 +++++++++++
 tb/tb_add2_unpack.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add2_unpack_if.sv
// rtl/add2_unpack_if.sv - sum/diff input stream and recovered-operand output stream
interface add2_unpack_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W:0]   in_sum;
   logic [DATA_W:0]   in_diff;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic              out_err;

   modport master (
      output in_valid, in_sum, in_diff, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_err
   );

   modport slave (
      input  in_valid, in_sum, in_diff, out_ready,
      output in_ready, out_valid, out_a, out_b, out_err
   );
endinterface

// File: rtl/add2_unpack.sv
// rtl/add2_unpack.sv - recover operand pairs (a, b) from (a+b, a-b) result pairs
// Defining ADD2_UNPACK_CHECK_EN adds the consistency check, out_err and err_count.
module add2_unpack #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   add2_unpack_if.slave     bus,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] pair_count,
   output logic [CNT_W-1:0] err_count
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W:0]   s1_sum_q;
   logic [DATA_W:0]   s1_diff_q;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_a_q;
   logic [DATA_W-1:0] s2_b_q;
   logic [DATA_W-1:0] rec_a;
   logic [DATA_W-1:0] rec_b;
   logic [CNT_W-1:0]  pair_q, pair_d;
   logic              s2_can_load;
   logic              in_xfer;
   logic              out_xfer;

   assign s2_can_load  = !s2_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s2_can_load;
   assign in_xfer      = bus.in_valid && bus.in_ready;
   assign out_xfer     = s2_valid_q && bus.out_ready;

   // sum+diff = 2a and sum-diff = 2b modulo 2^(W+1); the halving drops the carry-free lsb
   assign rec_a = DATA_W'((s1_sum_q + s1_diff_q) >> 1);
   assign rec_b = DATA_W'((s1_sum_q - s1_diff_q) >> 1);

   always_comb begin
      s1_valid_d = in_xfer || (s1_valid_q && !s2_can_load);
      s2_valid_d = s2_can_load ? s1_valid_q : s2_valid_q;
      pair_d     = pair_q;
      if (clr_stats) begin
         pair_d = '0;
      end else if (out_xfer && pair_q != CNT_MAX) begin
         pair_d = pair_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_diff_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_a_q     <= '0;
         s2_b_q     <= '0;
         pair_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         pair_q     <= pair_d;
         if (in_xfer) begin
            s1_sum_q  <= bus.in_sum;
            s1_diff_q <= bus.in_diff;
         end
         if (s2_can_load && s1_valid_q) begin
            s2_a_q <= rec_a;
            s2_b_q <= rec_b;
         end
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_a     = s2_a_q;
   assign bus.out_b     = s2_b_q;
   assign pair_count    = pair_q;

`ifdef ADD2_UNPACK_CHECK_EN
   logic             err_d;
   logic             s2_err_q;
   logic [CNT_W-1:0] errc_q, errc_d;

   // Rebuild sum and diff from the recovered operands at full W+1 width
   always_comb begin
      err_d = (s1_sum_q[0] ^ s1_diff_q[0])
           || (({1'b0, rec_a} + {1'b0, rec_b}) != s1_sum_q)
           || (({1'b0, rec_a} - {1'b0, rec_b}) != s1_diff_q);
      errc_d = errc_q;
      if (clr_stats) begin
         errc_d = '0;
      end else if (out_xfer && s2_err_q && errc_q != CNT_MAX) begin
         errc_d = errc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_err_q <= 1'b0;
         errc_q   <= '0;
      end else begin
         errc_q <= errc_d;
         if (s2_can_load && s1_valid_q) begin
            s2_err_q <= err_d;
         end
      end
   end

   assign bus.out_err = s2_err_q;
   assign err_count   = errc_q;
`else
   assign bus.out_err = 1'b0;
   assign err_count   = '0;
`endif
endmodule

// File: tb/tb_add2_unpack.sv
// tb/tb_add2_unpack.sv - randomized and directed self-check of add2_unpack against a queue model
module tb_add2_unpack;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;
   localparam int M      = 1 << (DATA_W + 1);
   localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef ADD2_UNPACK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      int a;
      int b;
      int e;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             clr_stats;
   logic [CNT_W-1:0] pair_count;
   logic [CNT_W-1:0] err_count;

   add2_unpack_if #(.DATA_W(DATA_W)) bus ();

   add2_unpack #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .clr_stats  (clr_stats),
      .pair_count (pair_count),
      .err_count  (err_count)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   int   mpair = 0;
   int   merr  = 0;
   bit   prev_hold = 1'b0;
   int   prev_a, prev_b, prev_e;
   bit   stim_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Operand recovery and consistency rules in plain integer arithmetic
   function automatic exp_t model(input int s, input int d);
      exp_t r;
      r.a = ((s + d) % M) / 2;
      r.b = ((s - d + M) % M) / 2;
      r.e = int'(CHK && (((s % 2) != (d % 2)) || (((r.a + r.b) % M) != s)
                         || (((r.a - r.b + M) % M) != d)));
      return r;
   endfunction

   // Observe both streams mid-cycle; inputs only change just after posedge
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         mpair     = 0;
         merr      = 0;
         prev_hold = 1'b0;
      end else begin
         chk("pair_count", pair_count, mpair);
         chk("err_count", err_count, merr);
         if (prev_hold) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_a", bus.out_a, prev_a);
            chk("hold_b", bus.out_b, prev_b);
            chk("hold_err", bus.out_err, prev_e);
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_a", bus.out_a, e.a);
               chk("out_b", bus.out_b, e.b);
               chk("out_err", bus.out_err, e.e);
            end
            if (mpair < CMAX) mpair++;
            if (bus.out_err && merr < CMAX) merr++;
         end
         if (clr_stats) begin
            mpair = 0;
            merr  = 0;
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_a    = int'(bus.out_a);
         prev_b    = int'(bus.out_b);
         prev_e    = int'(bus.out_err);
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(int'(bus.in_sum), int'(bus.in_diff)));
      end
   end

   // Presents a pair and returns just after the posedge that accepts it; in_valid stays up
   task automatic send_pair(input int s, input int d);
      int n;
      bus.in_valid = 1'b1;
      bus.in_sum   = (DATA_W+1)'(s);
      bus.in_diff  = (DATA_W+1)'(d);
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      bus.in_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic wait_out();
      @(negedge clk);
      for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
      chk("wait_out_valid", bus.out_valid, 1);
   endtask

   task automatic pulse_clr();
      clr_stats = 1'b1;
      @(posedge clk);
      #1;
      clr_stats = 1'b0;
   endtask

   task automatic rand_pair(output int s, output int d);
      int a, b;
      if ($urandom_range(0, 4) == 0) begin
         s = int'($urandom_range(0, M - 1));
         d = int'($urandom_range(0, M - 1));
      end else begin
         a = int'($urandom_range(0, (1 << DATA_W) - 1));
         b = int'($urandom_range(0, (1 << DATA_W) - 1));
         s = (a + b) % M;
         d = (a - b + M) % M;
      end
   endtask

   initial begin
      exp_t r;
      int s, d;
      rst_n        = 1'b0;
      clr_stats    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sum   = '0;
      bus.in_diff  = '0;
      bus.out_ready = 1'b1;

      r = model(500, 300);
      chk("model_500_300_a", r.a, 144);
      chk("model_500_300_b", r.b, 100);
      r = model(50, 492);
      chk("model_neg_b", r.b, 35);

      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_a", bus.out_a, 0);
      chk("rst_out_b", bus.out_b, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_pair_count", pair_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // single pair, two-stage latency
      send_pair(300, 100);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_s1_not_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("lat_s2_valid", bus.out_valid, 1);
      chk("single_a", bus.out_a, 200);
      chk("single_b", bus.out_b, 100);
      chk("single_err", bus.out_err, 0);
      @(negedge clk);
      chk("single_pair_count", pair_count, 1);

      // negative difference and all-ones boundary, back to back
      @(posedge clk);
      #1;
      send_pair(50, 9'h1EC);
      send_pair(510, 0);
      bus.in_valid = 1'b0;
      wait_out();
      chk("neg_a", bus.out_a, 15);
      chk("neg_b", bus.out_b, 35);
      chk("neg_err", bus.out_err, 0);
      @(negedge clk);
      chk("max_a", bus.out_a, 255);
      chk("max_b", bus.out_b, 255);

      // inconsistent pairs
      @(posedge clk);
      #1;
      send_pair(7, 2);
      send_pair(500, 300);
      bus.in_valid = 1'b0;
      wait_out();
      chk("parity_err", bus.out_err, CHK ? 1 : 0);
      @(negedge clk);
      chk("bad_a", bus.out_a, 144);
      chk("bad_b", bus.out_b, 100);
      chk("bad_err", bus.out_err, CHK ? 1 : 0);
      @(negedge clk);
      chk("bad_err_count", err_count, CHK ? 2 : 0);
      chk("bad_pair_count", pair_count, 5);

      // backpressure: 5 pairs streamed, output stalled 4 cycles after the first accept
      idle(2);
      pulse_clr();
      fork
         begin
            for (int i = 0; i < 5; i++) send_pair(20 * i + 40, 2 * i);
            bus.in_valid = 1'b0;
         end
         begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready_low", bus.in_ready, 0);
               chk("bp_out_valid_held", bus.out_valid, 1);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      idle(8);
      chk("bp_pair_count", pair_count, 5);
      chk("bp_drained", exp_q.size(), 0);

      // saturation of the 4-bit counters
      pulse_clr();
      for (int i = 0; i < 20; i++) begin
         rand_pair(s, d);
         send_pair(s, d);
      end
      idle(6);
      chk("sat_pair_count", pair_count, CMAX);

      // clear coincident with an output transfer
      send_pair(300, 100);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("clr_xfer_valid", bus.out_valid, 1);
      pulse_clr();
      @(negedge clk);
      chk("clr_pair_count", pair_count, 0);
      chk("clr_err_count", err_count, 0);

      // randomized traffic with random backpressure and occasional clears
      stim_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               rand_pair(s, d);
               send_pair(s, d);
               if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
            bus.in_valid = 1'b0;
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
               clr_stats     = ($urandom_range(0, 31) == 0);
            end
            bus.out_ready = 1'b1;
            clr_stats     = 1'b0;
         end
      join
      idle(8);
      chk("rand_drained", exp_q.size(), 0);

      // asynchronous reset with two pairs in flight
      bus.out_ready = 1'b0;
      send_pair(100, 20);
      send_pair(200, 40);
      bus.in_valid = 1'b0;
      chk("rst_inflight_valid", bus.out_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_a", bus.out_a, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      idle(1);
      send_pair(100, 20);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_s1_not_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_a", bus.out_a, 60);
      chk("post_rst_b", bus.out_b, 40);
      idle(4);
      chk("post_rst_pair_count", pair_count, 1);
      chk("post_rst_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
